// File: rtl/ddr_init_seq.sv
// DDR1 power-up initialisation sequencer: waits for stable clocks, then walks
// the JEDEC power-up command sequence and hands the bus over via init_done.
module ddr_init_seq #(
  parameter logic [15:0] T_POWERUP = 16'd10000,
  parameter logic [15:0] T_RP      = 16'd3,
  parameter logic [15:0] T_MRD     = 16'd2,
  parameter logic [15:0] T_RFC     = 16'd7,
  parameter logic [15:0] T_DLL     = 16'd200,
  parameter logic [12:0] MR_VAL    = 13'h0061,
  parameter logic [12:0] EMR_VAL   = 13'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_ok,
  output logic        cke,
  output logic        cs_n,
  output logic        ras_n,
  output logic        cas_n,
  output logic        we_n,
  output logic [1:0]  ba,
  output logic [12:0] addr,
  output logic        init_done
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned BA_W   = 2;
  localparam int unsigned ST_W   = 4;
  localparam int unsigned CMD_W  = 4;

  // States
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_PWR_WAIT = 4'd1;
  localparam logic [3:0] ST_CKE_UP   = 4'd2;
  localparam logic [3:0] ST_PRE1     = 4'd3;
  localparam logic [3:0] ST_EMR      = 4'd4;
  localparam logic [3:0] ST_MR_DLL   = 4'd5;
  localparam logic [3:0] ST_PRE2     = 4'd6;
  localparam logic [3:0] ST_REF1     = 4'd7;
  localparam logic [3:0] ST_REF2     = 4'd8;
  localparam logic [3:0] ST_MR       = 4'd9;
  localparam logic [3:0] ST_DLL_WAIT = 4'd10;
  localparam logic [3:0] ST_DONE     = 4'd11;

  // Command encodings {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_LMR   = 4'b0000;

  localparam logic [12:0] ADDR_PRE_ALL = 13'h0400;
  localparam logic [12:0] ADDR_DLL_RST = 13'h0100;

  // Gaps clamped so that 0 and 1 both mean a one-cycle spacing
  localparam logic [15:0] P_PWR      = (T_POWERUP < 16'd2) ? 16'd1 : T_POWERUP;
  localparam logic [15:0] P_RP       = (T_RP      < 16'd2) ? 16'd1 : T_RP;
  localparam logic [15:0] P_MRD      = (T_MRD     < 16'd2) ? 16'd1 : T_MRD;
  localparam logic [15:0] P_RFC      = (T_RFC     < 16'd2) ? 16'd1 : T_RFC;
  localparam logic [15:0] P_DLL      = (T_DLL     < 16'd2) ? 16'd1 : T_DLL;
  // MR itself takes one cycle; DLL_WAIT covers the rest of the T_DLL gap
  localparam logic [15:0] P_DLL_TAIL = P_DLL - 16'd1;

  logic [ST_W-1:0]   state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cke_q, cke_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [BA_W-1:0]   ba_q, ba_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              init_done_q, init_done_d;
  logic              expire;

  // Next state, shared gap counter and next registered pin values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cke_d       = 1'b0;
    cmd_d       = CMD_DESEL;
    ba_d        = BA_W'(0);
    addr_d      = ADDR_W'(0);
    init_done_d = 1'b0;
    expire      = (cnt_q <= 16'd1);

    if (!expire) begin
      cnt_d = cnt_q - 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (clk_ok) begin
          state_d = ST_PWR_WAIT;
          cnt_d   = P_PWR;
        end
      end
      ST_PWR_WAIT: if (expire) begin state_d = ST_CKE_UP; cnt_d = 16'd2; end
      ST_CKE_UP:   if (expire) begin state_d = ST_PRE1;   cnt_d = P_RP;  end
      ST_PRE1:     if (expire) begin state_d = ST_EMR;    cnt_d = P_MRD; end
      ST_EMR:      if (expire) begin state_d = ST_MR_DLL; cnt_d = P_MRD; end
      ST_MR_DLL:   if (expire) begin state_d = ST_PRE2;   cnt_d = P_RP;  end
      ST_PRE2:     if (expire) begin state_d = ST_REF1;   cnt_d = P_RFC; end
      ST_REF1:     if (expire) begin state_d = ST_REF2;   cnt_d = P_RFC; end
      ST_REF2:     if (expire) begin state_d = ST_MR;     cnt_d = 16'd1; end
      ST_MR: begin
        if (expire) begin
          if (P_DLL_TAIL != 16'd0) begin
            state_d = ST_DLL_WAIT;
            cnt_d   = P_DLL_TAIL;
          end else begin
            state_d = ST_DONE;
            cnt_d   = CNT_W'(0);
          end
        end
      end
      ST_DLL_WAIT: if (expire) begin state_d = ST_DONE; cnt_d = CNT_W'(0); end
      ST_DONE:     cnt_d = CNT_W'(0);
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_W'(0);
      end
    endcase

    // Losing the clocks before hand-over aborts the sequence
    if (!clk_ok && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
      state_d = ST_IDLE;
      cnt_d   = CNT_W'(0);
    end

    // Background pin values for the state being entered or held
    case (state_d)
      ST_IDLE:     cmd_d = CMD_DESEL;
      ST_PWR_WAIT: cmd_d = CMD_NOP;
      ST_DONE: begin
        cke_d       = 1'b1;
        cmd_d       = CMD_NOP;
        init_done_d = 1'b1;
      end
      default: begin
        cke_d = 1'b1;
        cmd_d = CMD_NOP;
      end
    endcase

    // Commands are issued only on the first cycle of their state
    if (state_d != state_q) begin
      case (state_d)
        ST_PRE1, ST_PRE2: begin
          cmd_d  = CMD_PRE;
          addr_d = ADDR_PRE_ALL;
        end
        ST_EMR: begin
          cmd_d  = CMD_LMR;
          ba_d   = 2'b01;
          addr_d = EMR_VAL;
        end
        ST_MR_DLL: begin
          cmd_d  = CMD_LMR;
          addr_d = MR_VAL | ADDR_DLL_RST;
        end
        ST_REF1, ST_REF2: cmd_d = CMD_REF;
        ST_MR: begin
          cmd_d  = CMD_LMR;
          addr_d = MR_VAL;
        end
        default: ;
      endcase
    end
  end

  // State, counter and pin registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_W'(0);
      cke_q       <= 1'b0;
      cmd_q       <= CMD_DESEL;
      ba_q        <= BA_W'(0);
      addr_q      <= ADDR_W'(0);
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cke_q       <= cke_d;
      cmd_q       <= cmd_d;
      ba_q        <= ba_d;
      addr_q      <= addr_d;
      init_done_q <= init_done_d;
    end
  end

  assign cke       = cke_q;
  assign cs_n      = cmd_q[3];
  assign ras_n     = cmd_q[2];
  assign cas_n     = cmd_q[1];
  assign we_n      = cmd_q[0];
  assign ba        = ba_q;
  assign addr      = addr_q;
  assign init_done = init_done_q;

endmodule
